// File: rtl/spi_reg_ctrl_if.sv
// Bus bundle between the SPI bridge, the transaction controller and the register file.
// The master modport is the controller's view; the slave modport is the surrounding logic.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              cs_n;
    logic              byte_sync;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        reg_rdata;
    logic              busy;
    logic              rd_overrun;

    modport master (
        input  cs_n, byte_sync, data_in, reg_rdata,
        output data_out, reg_addr, reg_wdata, reg_wr, reg_rd, busy, rd_overrun
    );

    modport slave (
        output cs_n, byte_sync, data_in, reg_rdata,
        input  data_out, reg_addr, reg_wdata, reg_wr, reg_rd, busy, rd_overrun
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI byte-stream transaction controller: decodes command/data bytes from the bridge
// into register write/read strobes with optional auto-increment bursts.
module spi_reg_ctrl #(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_reg_ctrl_if.master    bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_DATA = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RD_DATA = 2'd3;

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    logic [1:0]        state_r,    state_s;
    logic              auto_inc_r, auto_inc_s;
    logic [ADDR_W-1:0] addr_r,     addr_s;
    logic [7:0]        wdata_r,    wdata_s;
    logic              wr_r,       wr_s;
    logic              rd_r,       rd_s;
    logic [7:0]        dout_r,     dout_s;
    logic [2:0]        cnt_r,      cnt_s;
    logic              busy_r,     busy_s;
    logic              ovr_r,      ovr_s;

    // Next-state and next-output decode; chip-select high overrides everything.
    always_comb begin
        state_s    = state_r;
        auto_inc_s = auto_inc_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        wr_s       = 1'b0;
        rd_s       = 1'b0;
        dout_s     = dout_r;
        cnt_s      = cnt_r;
        ovr_s      = ovr_r;

        if (bus.cs_n) begin
            state_s = ST_IDLE;
            cnt_s   = 3'd0;
            ovr_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.byte_sync) begin
                        auto_inc_s = bus.data_in[6];
                        addr_s     = bus.data_in[ADDR_W-1:0];
                        cnt_s      = 3'd0;
                        if (bus.data_in[7]) begin
                            state_s = ST_WR_DATA;
                        end else begin
                            rd_s    = 1'b1;
                            state_s = ST_RD_WAIT;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WR_DATA: begin
                    // The address advances the cycle after the write strobe so the
                    // strobe itself carries the address it was issued for.
                    if (wr_r && auto_inc_r) begin
                        addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        addr_s = addr_r;
                    end
                    if (bus.byte_sync) begin
                        wr_s    = 1'b1;
                        wdata_s = bus.data_in;
                    end else begin
                        wr_s    = 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (bus.byte_sync) begin
                        ovr_s = 1'b1;
                    end else begin
                        ovr_s = ovr_r;
                    end
                    if (cnt_r == RD_LAT_C) begin
                        dout_s  = bus.reg_rdata;
                        state_s = ST_RD_DATA;
                    end else begin
                        cnt_s   = cnt_r + 3'd1;
                    end
                end
                ST_RD_DATA: begin
                    // Without auto-increment further bytes just repeat data_out.
                    if (bus.byte_sync && auto_inc_r) begin
                        addr_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        rd_s    = 1'b1;
                        cnt_s   = 3'd0;
                        state_s = ST_RD_WAIT;
                    end else begin
                        state_s = ST_RD_DATA;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            auto_inc_r <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= 8'h00;
            wr_r       <= 1'b0;
            rd_r       <= 1'b0;
            dout_r     <= 8'h00;
            cnt_r      <= 3'd0;
            busy_r     <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            auto_inc_r <= auto_inc_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            wr_r       <= wr_s;
            rd_r       <= rd_s;
            dout_r     <= dout_s;
            cnt_r      <= cnt_s;
            busy_r     <= busy_s;
            ovr_r      <= ovr_s;
        end
    end

    assign bus.data_out   = dout_r;
    assign bus.reg_addr   = addr_r;
    assign bus.reg_wdata  = wdata_r;
    assign bus.reg_wr     = wr_r;
    assign bus.reg_rd     = rd_r;
    assign bus.busy       = busy_r;
    assign bus.rd_overrun = ovr_r;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: one instance with RD_LAT=1, one with RD_LAT=7,
// sharing one stimulus path selected by sel.
module tb_spi_reg_ctrl;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       cs_v;
    logic       bs_v;
    logic [7:0] din_v;
    logic [7:0] rdata1;
    logic [7:0] rdata7;
    logic [7:0] mem [64];
    logic [6:0] v7;
    logic [7:0] d7 [7];

    int  n_checks;
    int  n_err;
    int  rd_timer;
    logic [7:0] rd_exp;
    ev_t sb_q [$];
    ev_t ev;

    spi_reg_ctrl_if #(.ADDR_W(6)) bus1 ();
    spi_reg_ctrl_if #(.ADDR_W(6)) bus7 ();

    assign bus1.cs_n      = sel ? 1'b1 : cs_v;
    assign bus1.byte_sync = sel ? 1'b0 : bs_v;
    assign bus1.data_in   = din_v;
    assign bus1.reg_rdata = rdata1;
    assign bus7.cs_n      = sel ? cs_v : 1'b1;
    assign bus7.byte_sync = sel ? bs_v : 1'b0;
    assign bus7.data_in   = din_v;
    assign bus7.reg_rdata = rdata7;

    spi_reg_ctrl #(.ADDR_W(6), .RD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    spi_reg_ctrl #(.ADDR_W(6), .RD_LAT(7)) u_dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));

    logic       m_wr, m_rd, m_busy, m_ovr;
    logic [5:0] m_addr;
    logic [7:0] m_wdata, m_dout;
    int         m_lat;
    assign m_wr    = sel ? bus7.reg_wr     : bus1.reg_wr;
    assign m_rd    = sel ? bus7.reg_rd     : bus1.reg_rd;
    assign m_busy  = sel ? bus7.busy       : bus1.busy;
    assign m_ovr   = sel ? bus7.rd_overrun : bus1.rd_overrun;
    assign m_addr  = sel ? bus7.reg_addr   : bus1.reg_addr;
    assign m_wdata = sel ? bus7.reg_wdata  : bus1.reg_wdata;
    assign m_dout  = sel ? bus7.data_out   : bus1.data_out;
    assign m_lat   = sel ? 7 : 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file models: data is valid only exactly RD_LAT cycles after reg_rd.
    always @(posedge clk) begin
        rdata1 <= bus1.reg_rd ? mem[bus1.reg_addr] : 8'hEE;
        v7     <= {v7[5:0], bus7.reg_rd};
        d7[0]  <= mem[bus7.reg_addr];
        for (int i = 1; i < 7; i++) d7[i] <= d7[i-1];
    end
    assign rdata7 = v7[6] ? d7[6] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: strobes pop expected events, read data checked RD_LAT+1 later.
    always @(negedge clk) begin
        if (rd_timer > 0) begin
            rd_timer--;
            if (rd_timer == 0) chk("rd_data_out", {24'h0, m_dout}, {24'h0, rd_exp});
        end
        if (m_wr && m_rd) chk("strobe_excl", 32'd1, 32'd0);
        if (m_wr || m_rd) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {30'h0, m_wr, m_rd}, 32'd0);
            end else begin
                ev = sb_q.pop_front();
                chk("strobe_kind", {31'h0, m_wr}, {31'h0, ev.wr});
                chk("strobe_addr", {26'h0, m_addr}, {24'h0, ev.addr});
                if (m_wr) begin
                    chk("wdata", {24'h0, m_wdata}, {24'h0, ev.data});
                end else begin
                    rd_timer = m_lat + 1;
                    rd_exp   = ev.data;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bs_v  = 1'b1;
        din_v = b;
        @(posedge clk); #1;
        bs_v  = 1'b0;
    endtask

    task automatic set_cs(input logic v);
        @(posedge clk); #1;
        cs_v = v;
    endtask

    task automatic push_ev(input logic wr, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.wr   = wr;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"},  {24'h0, m_dout},  32'd0);
        chk({tag, "_addr"},  {26'h0, m_addr},  32'd0);
        chk({tag, "_wdata"}, {24'h0, m_wdata}, 32'd0);
        chk({tag, "_strb"},  {30'h0, m_wr, m_rd}, 32'd0);
        chk({tag, "_busy"},  {31'h0, m_busy},  32'd0);
        chk({tag, "_ovr"},   {31'h0, m_ovr},   32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rd_timer = 0;
        rd_exp   = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'hFF;
        mem[18] = 8'h3C;
        rst_n = 1'b0;
        sel   = 1'b0;
        cs_v  = 1'b1;
        bs_v  = 1'b0;
        din_v = 8'h00;
        idle(3);
        chk_all_zero("reset1");
        sel = 1'b1;
        chk_all_zero("reset7");
        sel = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Single write
        set_cs(1'b0);
        send_byte(8'h85);
        idle(3);
        chk("wr_busy_cmd", {31'h0, m_busy}, 32'd1);
        push_ev(1'b1, 8'h05, 8'hA5);
        send_byte(8'hA5);
        idle(4);
        chk("wr_busy_data", {31'h0, m_busy}, 32'd1);
        set_cs(1'b1);
        idle(2);
        chk("wr_busy_end", {31'h0, m_busy}, 32'd0);

        // Single read, second byte repeats data without a strobe
        set_cs(1'b0);
        push_ev(1'b0, 8'h12, 8'h3C);
        send_byte(8'h12);
        idle(6);
        send_byte(8'hAA);
        idle(4);
        chk("rd_repeat_dout", {24'h0, m_dout}, 32'h3C);
        set_cs(1'b1);
        idle(2);

        // Burst write wrapping past the top address
        push_ev(1'b1, 8'h3E, 8'h11);
        push_ev(1'b1, 8'h3F, 8'h22);
        push_ev(1'b1, 8'h00, 8'h33);
        set_cs(1'b0);
        send_byte(8'hFE);
        idle(3);
        send_byte(8'h11);
        idle(3);
        send_byte(8'h22);
        idle(3);
        send_byte(8'h33);
        idle(3);
        set_cs(1'b1);
        idle(2);
        chk("burst_wr_addr", {26'h0, m_addr}, 32'h01);

        // Burst read with auto-increment
        set_cs(1'b0);
        push_ev(1'b0, 8'h00, 8'hFF);
        send_byte(8'h40);
        for (int k = 1; k < 4; k++) begin
            idle(5);
            push_ev(1'b0, 8'(k), mem[k]);
            send_byte(8'h5A);
        end
        idle(5);
        chk("burst_rd_last", {24'h0, m_dout}, 32'hFC);
        set_cs(1'b1);
        idle(2);

        // Abort after a write command, then a fresh read
        set_cs(1'b0);
        send_byte(8'h87);
        idle(2);
        set_cs(1'b1);
        idle(2);
        chk("abort_busy", {31'h0, m_busy}, 32'd0);
        set_cs(1'b0);
        push_ev(1'b0, 8'h01, 8'hFE);
        send_byte(8'h01);
        idle(5);
        set_cs(1'b1);
        idle(2);

        // Overrun with RD_LAT=7
        sel = 1'b1;
        idle(1);
        set_cs(1'b0);
        push_ev(1'b0, 8'h05, 8'hFA);
        send_byte(8'h05);
        repeat (3) @(posedge clk);
        #1;
        chk("ovr_before", {31'h0, m_ovr}, 32'd0);
        bs_v  = 1'b1;
        din_v = 8'h77;
        @(posedge clk); #1;
        bs_v  = 1'b0;
        idle(2);
        chk("ovr_set", {31'h0, m_ovr}, 32'd1);
        idle(10);
        chk("ovr_sticky", {31'h0, m_ovr}, 32'd1);
        chk("ovr_busy", {31'h0, m_busy}, 32'd1);
        set_cs(1'b1);
        idle(1);
        chk("ovr_clear", {31'h0, m_ovr}, 32'd0);
        idle(2);
        sel = 1'b0;
        idle(1);

        // Asynchronous reset in the middle of a burst read
        set_cs(1'b0);
        push_ev(1'b0, 8'h00, 8'hFF);
        send_byte(8'h40);
        idle(6);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(10);
        chk_all_zero("postrst");
        set_cs(1'b1);
        idle(2);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
